// File: rtl/traceback_walker.sv
// traceback_walker: walks the Needleman-Wunsch direction matrix from (N,N)
// back to (0,0). It reads one direction symbol per interior cell through the
// direction manager, then emits one alignment operation per step downstream.
//
// Step handshake: step_valid/step_op are offered and held stable until
// step_ready is seen high on a rising edge while step_valid is high. That edge
// is the accept: the coordinates update and step_cnt increments. step_valid
// never drops without an accept, except on rst.
module traceback_walker #(
    parameter int N       = 128,
    parameter int BitAddr = $clog2(N + 1),
    parameter int RD_LAT  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         symbol_in,
    input  logic               step_ready,
    output logic [BitAddr:0]   i_t,
    output logic [BitAddr:0]   j_t,
    output logic               en_traceB,
    output logic               step_valid,
    output logic [1:0]         step_op,
    output logic [BitAddr+1:0] step_cnt,
    output logic               busy,
    output logic               done,
    output logic               error
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        DECIDE = 3'd3,
        EDGE   = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    localparam logic [1:0] OP_DIAG = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_LEFT = 2'b10;

    localparam int WAIT_W    = $clog2(RD_LAT + 1);
    localparam int WAIT_INIT = (RD_LAT > 1) ? RD_LAT - 2 : 0;
    localparam logic [BitAddr:0] N_COORD = (BitAddr + 1)'(N);

    // Current FSM state; kept as a named register so checkers can bind to it.
    state_t            state;
    logic              first_q;   // high during the first DECIDE cycle of a cell
    logic [2:0]        sym_q;     // symbol captured in the first DECIDE cycle
    logic [WAIT_W-1:0] wait_cnt;

    logic [2:0]        sym_cur;
    logic              sym_ok;
    logic [1:0]        dec_op;
    logic [BitAddr:0]  next_i;
    logic [BitAddr:0]  next_j;

    // The first DECIDE cycle uses the live RAM data so a step can be offered
    // RD_LAT cycles after ISSUE; stalled cycles use the captured copy so RAM
    // output changes cannot disturb a pending step.
    assign sym_cur = first_q ? symbol_in : sym_q;
    assign sym_ok  = |sym_cur;

    // Status outputs are pure decodes of the state register.
    assign en_traceB = (state == ISSUE) || (state == WAIT) || (state == DECIDE);
    assign busy      = en_traceB || (state == EDGE);
    assign done      = (state == DONE);
    assign error     = (state == ERR);

    // Decode the symbol (diag > up > left), build the offered step and the
    // coordinates it leads to; only a nonzero coordinate is ever decremented.
    always_comb begin
        dec_op     = OP_LEFT;
        step_valid = 1'b0;
        step_op    = OP_DIAG;
        next_i     = i_t;
        next_j     = j_t;
        if (sym_cur[2]) begin
            dec_op = OP_DIAG;
        end else if (sym_cur[1]) begin
            dec_op = OP_UP;
        end
        if (state == DECIDE) begin
            step_valid = sym_ok;
            step_op    = sym_ok ? dec_op : OP_DIAG;
        end else if (state == EDGE) begin
            step_valid = 1'b1;
            step_op    = (i_t == '0) ? OP_LEFT : OP_UP;
        end
        if ((step_op == OP_DIAG || step_op == OP_UP) && i_t != '0) begin
            next_i = i_t - 1'b1;
        end
        if ((step_op == OP_DIAG || step_op == OP_LEFT) && j_t != '0) begin
            next_j = j_t - 1'b1;
        end
    end

    // Walk FSM: coordinate, step counter, read-latency counter and symbol capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            i_t      <= '0;
            j_t      <= '0;
            step_cnt <= '0;
            first_q  <= 1'b0;
            sym_q    <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        i_t      <= N_COORD;
                        j_t      <= N_COORD;
                        step_cnt <= '0;
                        state    <= (N == 0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= WAIT_W'(WAIT_INIT);
                    first_q  <= 1'b1;
                    state    <= (RD_LAT <= 1) ? DECIDE : WAIT;
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= DECIDE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                DECIDE: begin
                    if (first_q) begin
                        sym_q   <= symbol_in;
                        first_q <= 1'b0;
                    end
                    if (!sym_ok) begin
                        state <= ERR;
                    end else if (step_ready) begin
                        i_t      <= next_i;
                        j_t      <= next_j;
                        step_cnt <= step_cnt + 1'b1;
                        if (next_i == '0 && next_j == '0) begin
                            state <= DONE;
                        end else if (next_i == '0 || next_j == '0) begin
                            state <= EDGE;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                EDGE: begin
                    if (step_ready) begin
                        i_t      <= next_i;
                        j_t      <= next_j;
                        step_cnt <= step_cnt + 1'b1;
                        if (next_i == '0 && next_j == '0) begin
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_traceback_walker.sv
// Bench for traceback_walker: a RAM model with read latency feeds symbol_in,
// a reference walk over the matrix fills the expected-step queue, and a
// monitor pops and compares every accepted step.
module tb_traceback_walker;

    localparam int N      = 4;
    localparam int BA     = $clog2(N + 1);
    localparam int RD_LAT = 2;
    localparam int W      = 1 + 2 * (BA + 1) + 2;

    localparam logic [1:0] OP_DIAG = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_LEFT = 2'b10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    symbol_in = 3'b000;
    logic          step_ready = 1'b0;
    logic [BA:0]   i_t;
    logic [BA:0]   j_t;
    logic          en_traceB;
    logic          step_valid;
    logic [1:0]    step_op;
    logic [BA+1:0] step_cnt;
    logic          busy;
    logic          done;
    logic          error;

    traceback_walker #(.N(N), .BitAddr(BA), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .symbol_in(symbol_in),
        .step_ready(step_ready), .i_t(i_t), .j_t(j_t), .en_traceB(en_traceB),
        .step_valid(step_valid), .step_op(step_op), .step_cnt(step_cnt),
        .busy(busy), .done(done), .error(error)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- shared state ----------------
    logic [2:0]   mem [0:N][0:N];
    logic [W-1:0] exp_q[$];       // {edge, i, j, op}
    int           acc_cyc[$];
    bit           acc_edge[$];
    int           n_checks = 0;
    int           n_fail = 0;
    int           issue_cyc = 0;
    bit           rnd_ready = 1'b0;
    bit           exp_err;
    int           exp_fi, exp_fj, exp_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [2:0] v);
        for (int a = 0; a <= N; a++)
            for (int b = 0; b <= N; b++)
                mem[a][b] = v;
    endtask

    // Reference walk: follow the matrix by the alignment rules and list every step.
    task automatic model_walk;
        int i, j;
        logic [2:0] s;
        i = N; j = N; exp_err = 1'b0; exp_cnt = 0;
        while (i != 0 || j != 0) begin
            if (i > 0 && j > 0) begin
                s = mem[i][j];
                if (s == 3'b000) begin
                    exp_err = 1'b1;
                    break;
                end
                if (s[2]) begin
                    exp_q.push_back({1'b0, (BA + 1)'(i), (BA + 1)'(j), OP_DIAG});
                    i--; j--;
                end else if (s[1]) begin
                    exp_q.push_back({1'b0, (BA + 1)'(i), (BA + 1)'(j), OP_UP});
                    i--;
                end else begin
                    exp_q.push_back({1'b0, (BA + 1)'(i), (BA + 1)'(j), OP_LEFT});
                    j--;
                end
            end else if (i == 0) begin
                exp_q.push_back({1'b1, (BA + 1)'(0), (BA + 1)'(j), OP_LEFT});
                j--;
            end else begin
                exp_q.push_back({1'b1, (BA + 1)'(i), (BA + 1)'(0), OP_UP});
                i--;
            end
            exp_cnt++;
        end
        exp_fi = i;
        exp_fj = j;
    endtask

    // ---------------- RAM model with RD_LAT latency ----------------
    // During a stalled step the output is replaced by noise.
    initial begin
        logic [2:0]  pipe [RD_LAT];
        logic        c_en, c_stall;
        logic [BA:0] ci, cj;
        for (int k = 0; k < RD_LAT; k++) pipe[k] = 3'b000;
        forever begin
            @(negedge clk);
            c_en    = en_traceB;
            ci      = i_t;
            cj      = j_t;
            c_stall = step_valid && !step_ready && en_traceB;
            @(posedge clk);
            #1;
            for (int k = RD_LAT - 1; k > 0; k--) pipe[k] = pipe[k - 1];
            pipe[0] = (c_en && int'(ci) <= N && int'(cj) <= N) ? mem[int'(ci)][int'(cj)] : 3'($urandom);
            symbol_in = c_stall ? 3'($urandom) : pipe[RD_LAT - 1];
        end
    end

    // ---------------- random ready driver ----------------
    initial begin
        forever begin
            tick;
            if (rnd_ready) step_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic         stalled;
        logic [1:0]   p_op;
        logic [BA:0]  p_i, p_j;
        logic         p_en;
        logic [W-1:0] e;
        stalled = 1'b0;
        p_op = '0; p_i = '0; p_j = '0; p_en = 1'b0;
        forever begin
            @(negedge clk);
            if (stalled && !rst) begin
                chk("stall_hold", {20'd0, step_valid, step_op, i_t, j_t, en_traceB},
                    {20'd0, 1'b1, p_op, p_i, p_j, p_en});
            end
            if (step_valid && step_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_step: op=%0d at (%0d,%0d), none required", step_op, i_t, j_t);
                end else begin
                    e = exp_q.pop_front();
                    chk("step", {21'd0, ~en_traceB, i_t, j_t, step_op}, {21'd0, e});
                    acc_cyc.push_back(cyc);
                    acc_edge.push_back(e[W-1]);
                end
            end
            stalled = step_valid && !step_ready && !rst;
            p_op = step_op; p_i = i_t; p_j = j_t; p_en = en_traceB;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_idle(input string tag);
        chk({tag, "_i"}, i_t, 0);
        chk({tag, "_j"}, j_t, 0);
        chk({tag, "_en"}, en_traceB, 0);
        chk({tag, "_valid"}, step_valid, 0);
        chk({tag, "_op"}, step_op, 0);
        chk({tag, "_cnt"}, step_cnt, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    task automatic start_walk;
        acc_cyc.delete();
        acc_edge.delete();
        model_walk();
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        issue_cyc = cyc;
        chk("start_busy", busy, 1);
        chk("start_i", i_t, N);
        chk("start_j", j_t, N);
        chk("start_en", en_traceB, 1);
        chk("start_cnt", step_cnt, 0);
        chk("start_flags", {done, error}, 0);
    endtask

    task automatic finish_walk(input bit chk_gaps);
        int k;
        int end_cyc;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && !error && k < 400);
        if (!done && !error) begin
            n_checks++;
            n_fail++;
            $display("FAIL walk_timeout: no done or error after %0d cycles", k);
            exp_q.delete();
            return;
        end
        end_cyc = cyc;
        chk("end_error", error, exp_err);
        chk("end_done", done, !exp_err);
        chk("end_cnt", step_cnt, exp_cnt);
        chk("end_i", i_t, exp_fi);
        chk("end_j", j_t, exp_fj);
        chk("end_busy", busy, 0);
        chk("end_queue", exp_q.size(), 0);
        exp_q.delete();
        if (!exp_err && acc_cyc.size() > 0) chk("done_latency", end_cyc - acc_cyc[$], 1);
        if (chk_gaps && acc_cyc.size() > 0) begin
            chk("first_latency", acc_cyc[0] - issue_cyc, RD_LAT);
            for (int m = 1; m < acc_cyc.size(); m++)
                chk("step_gap", acc_cyc[m] - acc_cyc[m - 1], acc_edge[m] ? 1 : RD_LAT + 1);
        end
    endtask

    task automatic wait_coord(input int ci, input int cj);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(int'(i_t) == ci && int'(j_t) == cj && en_traceB) && k < 100);
        if (!(int'(i_t) == ci && int'(j_t) == cj && en_traceB)) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_coord: (%0d,%0d) not reached, at (%0d,%0d)", ci, cj, i_t, j_t);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        fill(3'b100);
        rst = 1'b1;
        repeat (3) tick;
        check_idle("reset");
        rst = 1'b0;
        tick;
        check_idle("post_reset");
        step_ready = 1'b1;

        // all DIAG, ready high
        fill(3'b100);
        start_walk();
        finish_walk(1'b1);

        // all LEFT: interior LEFTs to (4,0), then forced UPs along column 0
        fill(3'b001);
        start_walk();
        finish_walk(1'b1);

        // tie symbols
        for (int a = 0; a <= N; a++)
            for (int b = 0; b <= N; b++)
                case ($urandom_range(0, 2))
                    0: mem[a][b] = 3'b110;
                    1: mem[a][b] = 3'b011;
                    default: mem[a][b] = 3'b111;
                endcase
        start_walk();
        finish_walk(1'b1);

        // invalid symbol after one DIAG, then a clean restart
        fill(3'b100);
        mem[3][3] = 3'b000;
        start_walk();
        finish_walk(1'b0);
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("err_no_step", step_valid, 0);
            chk("err_held", {error, i_t, j_t}, {1'b1, 4'd3, 4'd3});
        end
        mem[3][3] = 3'b100;
        start_walk();
        finish_walk(1'b1);

        // stall during the (3,3) DIAG step with noisy RAM output; start ignored
        start_walk();
        wait_coord(3, 3);
        tick;
        step_ready = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (5) tick;
        step_ready = 1'b1;
        finish_walk(1'b0);

        // synchronous reset mid-walk, then a fresh walk
        start_walk();
        wait_coord(2, 2);
        tick;
        rst = 1'b1;
        exp_q.delete();
        tick;
        check_idle("mid_reset");
        rst = 1'b0;
        tick;
        chk("idle_stays", {busy, done, error}, 0);
        start_walk();
        finish_walk(1'b1);

        // random matrices with random backpressure
        rnd_ready = 1'b1;
        for (int w = 0; w < 8; w++) begin
            for (int a = 0; a <= N; a++)
                for (int b = 0; b <= N; b++)
                    mem[a][b] = ($urandom_range(0, 19) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
            start_walk();
            finish_walk(1'b0);
        end
        rnd_ready = 1'b0;
        step_ready = 1'b1;
        repeat (3) tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
